stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; the legal range is 2..8.
REQ-002 Parameter DATA_WIDTH, default 8, width of the data path on both sides.
REQ-003 Parameter MAX_BEATS, default 256, maximum beats per grant before forced release; the legal range is 2..65535.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  per-requester last beat of packet.
REQ-009 req_ready  output  NUM_REQ  per-requester ready.
REQ-010 stream_out_valid  output  1  shared stream valid.
REQ-011 stream_out_data  output  DATA_WIDTH  shared stream data.
REQ-012 stream_out_last  output  1  shared stream last.
REQ-013 stream_out_ready  input  1  shared stream ready from the downstream sink.
REQ-014 grant_valid  output  1  high while a grant is held.
REQ-015 grant_idx  output  3  index of the current or most recent grantee.
REQ-016 beat_count  output  16  beats accepted in the current grant.
REQ-017 overrun_err  output  1  sticky flag, set on forced release.

Function
REQ-018 A beat SHALL transfer when valid and ready are both high at a rising clk edge.
REQ-019 The FSM SHALL have states IDLE and BUSY.
REQ-020 In IDLE, when any req_valid is high, the FSM SHALL pick the first requester with valid set, searching round-robin from grant_idx+1 modulo NUM_REQ.
REQ-021 On that pick, the FSM SHALL register the choice into grant_idx and enter BUSY on the next edge, giving 1 cycle of arbitration latency.
REQ-022 In IDLE, stream_out_valid SHALL be 0 and all req_ready SHALL be 0.
REQ-023 In BUSY, stream_out_valid, stream_out_data and stream_out_last SHALL follow the granted requester combinationally.
REQ-024 In BUSY, req_ready[grant_idx] SHALL equal stream_out_ready, and every other req_ready bit SHALL be 0.
REQ-025 In BUSY, each transferred beat SHALL increment beat_count; beat_count SHALL clear to 0 on entry to BUSY.
REQ-026 A transferred beat with req_last=1 SHALL return the FSM to IDLE on the same edge.
REQ-027 A transferred beat without last that brings beat_count to MAX_BEATS SHALL force a return to IDLE and set overrun_err.
REQ-028 overrun_err SHALL stay set until reset.
REQ-029 grant_idx SHALL hold its value in IDLE so that round-robin fairness is preserved.
REQ-030 After a release, a new grant SHALL take at least 1 IDLE cycle; there is no back-to-back grant.
REQ-031 The grantee deasserting req_valid mid-packet SHALL NOT release the grant; only last or forced release returns to IDLE.
REQ-032 Changes on req_valid of non-granted requesters during BUSY SHALL have no effect on the grant.
REQ-033 grant_valid SHALL be 1 exactly in BUSY.

Reset
REQ-034 reset_n low SHALL force, asynchronously: state IDLE, grant_idx=NUM_REQ-1 (so requester 0 wins first), beat_count=0 and overrun_err=0.
REQ-035 While reset_n is low, all outputs SHALL be 0 except grant_idx.
REQ-036 Reset asserted mid-packet SHALL drop the grant immediately; no partial beat SHALL be issued after release.
REQ-037 Reset deassertion SHALL be synchronised externally.

Structure
REQ-038 Package stream_arbiter_pkg SHALL hold the FSM state enum and the beat_count width constant (16).
REQ-039 Sub-module rr_pick SHALL be a combinational round-robin priority picker taking a request vector and the last index, and returning a next index and a found flag.

Verification
REQ-040 Contention: after reset, req_valid=4'b1111 with 1-beat packets and stream_out_ready=1 -> grants SHALL occur in order 0,1,2,3,0, one beat every 2 cycles.
REQ-041 Packet hold: requester 2 sends 5 beats 0xA0..0xA4 with last on 0xA4 while requester 1 is valid -> requester 2's beats SHALL be contiguous, beat_count SHALL reach 5, and requester 1 SHALL be granted next.
REQ-042 Backpressure: stream_out_ready toggling 1,0,0,1 during a 3-beat packet -> no beat SHALL be lost or duplicated, and req_ready SHALL mirror stream_out_ready.
REQ-043 Overrun: MAX_BEATS=4, requester 0 streams 6 beats without last -> release SHALL occur after beat 4, overrun_err=1, and requester 0 SHALL be re-granted only if it is the sole requester.
REQ-044 Reset: reset_n pulsed low at beat 2 of a packet -> grant_valid=0, beat_count=0 and overrun_err=0 SHALL appear without a clock edge, and the next grant SHALL go to requester 0.

Source files
------------

// File: rtl/stream_arbiter_pkg.sv
// Shared types and constants for the packet-level round-robin stream arbiter.
package stream_arbiter_pkg;

    localparam int BEAT_CNT_W = 16;
    localparam int IDX_W      = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping modulo NUM_REQ.
module rr_pick
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found
);

    // Distances are scanned from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        next_idx = last_idx;
        found    = 1'b0;
        for (int d = NUM_REQ; d >= 1; d--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && (((int'(last_idx) + d) % NUM_REQ) == i)) begin
                    next_idx = IDX_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ valid/ready streams into one output stream.
// Handshake: a beat moves on a rising clk edge when valid and ready are both high; valid never waits on ready.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          stream_out_valid,
    output logic [DATA_WIDTH-1:0]         stream_out_data,
    output logic                          stream_out_last,
    input  logic                          stream_out_ready,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic [BEAT_CNT_W-1:0]         beat_count,
    output logic                          overrun_err,
    output arb_state_e                    state_dbg
);

    localparam logic [BEAT_CNT_W-1:0] MAX_CNT = BEAT_CNT_W'(MAX_BEATS);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                    ovr_q, ovr_d;

    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;

    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    busy;
    logic                    beat_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req      (req_valid),
        .last_idx (grant_q),
        .next_idx (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy      = (state_q == ARB_BUSY);
    assign beat_fire = busy && sel_valid && stream_out_ready;
    assign cnt_inc   = cnt_q + 1'b1;

    // Only last or the beat limit ends a grant; a grantee dropping valid simply stalls it.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_BUSY: begin
                if (beat_fire) begin
                    cnt_d = cnt_inc;
                    if (sel_last) begin
                        state_d = ARB_IDLE;
                    end else if (cnt_inc == MAX_CNT) begin
                        state_d = ARB_IDLE;
                        ovr_d   = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // grant_q resets to the top index so requester 0 is the first one searched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy && (grant_q == IDX_W'(i))) begin
                req_ready[i] = stream_out_ready;
            end
        end
    end

    assign stream_out_valid = busy && sel_valid;
    assign stream_out_data  = busy ? sel_data : '0;
    assign stream_out_last  = busy && sel_last;
    assign grant_valid      = busy;
    assign grant_idx        = grant_q;
    assign beat_count       = cnt_q;
    assign overrun_err      = ovr_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: two instances (MAX_BEATS 256 and 4) share stimulus and are checked
// every cycle against a packet-level reference model, plus directed ordering/reset scenarios.
module tb_stream_arbiter;
    import stream_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic              stream_out_ready;

    logic [N-1:0]      rdy [2];
    logic              sov [2];
    logic [DW-1:0]     sod [2];
    logic              sol [2];
    logic              gv  [2];
    logic [2:0]        gi  [2];
    logic [15:0]       bc  [2];
    logic              oe  [2];
    arb_state_e        st  [2];

    stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(256)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rdy[0]), .stream_out_valid(sov[0]),
        .stream_out_data(sod[0]), .stream_out_last(sol[0]), .stream_out_ready(stream_out_ready),
        .grant_valid(gv[0]), .grant_idx(gi[0]), .beat_count(bc[0]), .overrun_err(oe[0]),
        .state_dbg(st[0])
    );

    stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rdy[1]), .stream_out_valid(sov[1]),
        .stream_out_data(sod[1]), .stream_out_last(sol[1]), .stream_out_ready(stream_out_ready),
        .grant_valid(gv[1]), .grant_idx(gi[1]), .beat_count(bc[1]), .overrun_err(oe[1]),
        .state_dbg(st[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one packet-level view per instance.
    bit m_busy  [2];
    int m_owner [2];
    int m_cnt   [2];
    bit m_ovr   [2];
    bit m_xfer  [2];
    int m_max   [2];

    // Per-requester beat sources: {last, data}.
    logic [8:0]  src_q [N][$];
    logic [N-1:0] gap_mask;
    int pop_ref;
    int rec_ref;
    int cyc;

    logic [10:0] exp_q [$];
    logic [10:0] got_q [$];
    int          got_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int m);
        m_busy[m]  = 1'b0;
        m_owner[m] = N - 1;
        m_cnt[m]   = 0;
        m_ovr[m]   = 1'b0;
        m_xfer[m]  = 1'b0;
    endtask

    task automatic model_step();
        bit f;
        int k;
        for (int m = 0; m < 2; m++) begin
            m_xfer[m] = 1'b0;
            if (!reset_n) begin
                model_reset(m);
            end else if (!m_busy[m]) begin
                f = 1'b0;
                for (int d = 1; d <= N; d++) begin
                    k = (m_owner[m] + d) % N;
                    if (!f && req_valid[k]) begin
                        f          = 1'b1;
                        m_owner[m] = k;
                        m_busy[m]  = 1'b1;
                        m_cnt[m]   = 0;
                    end
                end
            end else if (req_valid[m_owner[m]] && stream_out_ready) begin
                m_xfer[m] = 1'b1;
                m_cnt[m]++;
                if (req_last[m_owner[m]]) begin
                    m_busy[m] = 1'b0;
                end else if (m_cnt[m] == m_max[m]) begin
                    m_busy[m] = 1'b0;
                    m_ovr[m]  = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_rdy;
        logic [DW-1:0] e_data;
        string t;
        for (int m = 0; m < 2; m++) begin
            t = $sformatf("c%0d_d%0d", cyc, m);
            e_rdy = '0;
            if (m_busy[m] && stream_out_ready) e_rdy[m_owner[m]] = 1'b1;
            chk({t, "_grant_valid"}, gv[m], m_busy[m]);
            chk({t, "_grant_idx"},   gi[m], m_owner[m]);
            chk({t, "_beat_count"},  bc[m], m_cnt[m]);
            chk({t, "_overrun"},     oe[m], m_ovr[m]);
            chk({t, "_out_valid"},   sov[m], m_busy[m] && req_valid[m_owner[m]]);
            chk({t, "_req_ready"},   rdy[m], e_rdy);
            chk({t, "_state"},       32'(st[m]), m_busy[m] ? 32'(ARB_BUSY) : 32'(ARB_IDLE));
            if (m_busy[m] || !reset_n) begin
                e_data = m_busy[m] ? req_data[m_owner[m]*DW +: DW] : '0;
                chk({t, "_out_data"}, sod[m], e_data);
                chk({t, "_out_last"}, sol[m], m_busy[m] && req_last[m_owner[m]]);
            end
        end
    endtask

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !gap_mask[i]) begin
                h = src_q[i][0];
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = h[7:0];
                req_last[i]            = h[8];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic tick();
        drive_inputs();
        #1;
        check_all();
        if (reset_n && gv[rec_ref] && sov[rec_ref] && stream_out_ready) begin
            got_q.push_back({gi[rec_ref], sod[rec_ref]});
            got_cyc.push_back(cyc);
        end
        model_step();
        if (m_xfer[pop_ref] && src_q[m_owner[pop_ref]].size() > 0)
            void'(src_q[m_owner[pop_ref]].pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_pkt(input int i, input logic [7:0] base, input int len, input bit with_last);
        for (int k = 0; k < len; k++)
            src_q[i].push_back({with_last && (k == len - 1), 8'(base + 8'(k))});
    endtask

    task automatic expect_beats(input logic [2:0] idx, input logic [7:0] base, input int len);
        for (int k = 0; k < len; k++) exp_q.push_back({idx, 8'(base + 8'(k))});
    endtask

    task automatic compare_got(input string tag);
        chk({tag, "_beats"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("%s_beat%0d", tag, k), got_q[k], exp_q[k]);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    // Asserts reset between edges and checks the outputs before any clock edge arrives.
    task automatic reset_pulse(input string tag);
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        gap_mask = '0;
        drive_inputs();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s_d%0d_grant_valid", tag, m), gv[m], 1'b0);
            chk($sformatf("%s_d%0d_beat_count", tag, m), bc[m], 16'd0);
            chk($sformatf("%s_d%0d_overrun", tag, m), oe[m], 1'b0);
            chk($sformatf("%s_d%0d_out_valid", tag, m), sov[m], 1'b0);
            chk($sformatf("%s_d%0d_out_data", tag, m), sod[m], 8'd0);
            chk($sformatf("%s_d%0d_out_last", tag, m), sol[m], 1'b0);
            chk($sformatf("%s_d%0d_req_ready", tag, m), rdy[m], 4'd0);
            chk($sformatf("%s_d%0d_grant_idx", tag, m), gi[m], N - 1);
        end
        model_reset(0);
        model_reset(1);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        logic [7:0] b;
        int len, who;
        logic [3:0] pat;

        m_max[0] = 256;
        m_max[1] = 4;
        pop_ref = 0;
        rec_ref = 0;
        cyc = 0;
        gap_mask = '0;
        stream_out_ready = 1'b0;
        reset_n = 1'b1;
        drive_inputs();
        #1;

        // Power-on reset, checked before the first clock edge.
        reset_pulse("por");

        // Contention: four 1-beat requesters, requester 0 twice.
        stream_out_ready = 1'b1;
        for (int i = 0; i < N; i++) push_pkt(i, 8'(8'h10 + 8'(i)), 1, 1'b1);
        push_pkt(0, 8'h14, 1, 1'b1);
        run(10);
        for (int k = 0; k < N; k++) exp_q.push_back({3'(k), 8'(8'h10 + 8'(k))});
        exp_q.push_back({3'd0, 8'h14});
        for (int k = 1; k < got_cyc.size(); k++)
            chk($sformatf("contention_spacing%0d", k), got_cyc[k] - got_cyc[k-1], 2);
        compare_got("contention");

        // Packet hold: make requester 1 the last grantee, then requester 2 wins over it.
        push_pkt(1, 8'h30, 1, 1'b1);
        run(3);
        got_q.delete();
        got_cyc.delete();
        push_pkt(2, 8'hA0, 5, 1'b1);
        push_pkt(1, 8'h31, 1, 1'b1);
        peak = 0;
        repeat (10) begin
            tick();
            if (gi[0] == 3'd2 && int'(bc[0]) > peak) peak = int'(bc[0]);
        end
        chk("hold_peak_beat_count", peak, 5);
        if (got_cyc.size() >= 5)
            for (int k = 1; k < 5; k++)
                chk($sformatf("hold_contiguous%0d", k), got_cyc[k] - got_cyc[k-1], 1);
        expect_beats(3'd2, 8'hA0, 5);
        expect_beats(3'd1, 8'h31, 1);
        compare_got("hold");

        // Backpressure: ready pattern 1,0,0,1 repeating over a 3-beat packet.
        pat = 4'b1001;
        push_pkt(3, 8'hB0, 3, 1'b1);
        for (int k = 0; k < 12; k++) begin
            stream_out_ready = pat[3 - (k % 4)];
            tick();
        end
        stream_out_ready = 1'b1;
        expect_beats(3'd3, 8'hB0, 3);
        compare_got("backpressure");

        // Overrun, sole requester: forced release after 4 beats, then re-grant to 0.
        reset_pulse("rst_a");
        pop_ref = 1;
        rec_ref = 1;
        push_pkt(0, 8'hC0, 6, 1'b0);
        run(12);
        chk("ovr_sole_flag", oe[1], 1'b1);
        chk("ovr_sole_flag_big", oe[0], 1'b0);
        if (got_cyc.size() >= 5) chk("ovr_sole_regrant_gap", got_cyc[4] - got_cyc[3], 2);
        expect_beats(3'd0, 8'hC0, 6);
        compare_got("ovr_sole");

        // Overrun with a competitor: requester 1 gets in after the forced release.
        reset_pulse("rst_b");
        push_pkt(0, 8'hD0, 6, 1'b0);
        push_pkt(1, 8'hE0, 1, 1'b1);
        run(14);
        chk("ovr_comp_flag", oe[1], 1'b1);
        expect_beats(3'd0, 8'hD0, 4);
        expect_beats(3'd1, 8'hE0, 1);
        expect_beats(3'd0, 8'hD4, 2);
        compare_got("ovr_comp");

        // Reset at beat 2 of a packet (dut0 still holds requester 0, dut1 has overrun set).
        pop_ref = 0;
        rec_ref = 0;
        push_pkt(0, 8'hF0, 4, 1'b1);
        for (int k = 0; k < 10 && src_q[0].size() > 2; k++) tick();
        chk("midpkt_beat2_reached", src_q[0].size(), 2);
        chk("midpkt_overrun_before", oe[1], 1'b1);
        reset_pulse("rst_mid");
        got_q.delete();
        got_cyc.delete();
        push_pkt(1, 8'h51, 1, 1'b1);
        push_pkt(0, 8'h50, 1, 1'b1);
        run(6);
        expect_beats(3'd0, 8'h50, 1);
        expect_beats(3'd1, 8'h51, 1);
        compare_got("post_reset");

        // Random traffic, valid gaps and backpressure against the model.
        reset_pulse("rst_rand");
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                who = $urandom_range(0, N - 1);
                if (src_q[who].size() < 8) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        b = 8'($urandom_range(0, 255));
                        src_q[who].push_back({(k == len - 1), b});
                    end
                end
            end
            stream_out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) gap_mask[i] = ($urandom_range(0, 5) == 0);
            tick();
        end
        gap_mask = '0;
        stream_out_ready = 1'b1;
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
